fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the RV32I core. It sits upstream of decode and the control unit, and owns the fetch program counter. It issues word requests to an instruction memory over a request/grant + in-order response interface, buffers returned instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. A redirect input (branch/jump/trap) flushes the buffered stream and discards in-flight responses.

## Interface
- `DEPTH`, default 4: FIFO entries and maximum in-flight requests. Power of two, ≥2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_req` output 1: fetch request offered this cycle.
- `imem_addr` output 32: word address of the request; bits [1:0] always 0.
- `imem_gnt` input 1: the request is accepted when `imem_req & imem_gnt`.
- `imem_rvalid` input 1: one response this cycle, in request order, at least 1 cycle after its grant.
- `imem_rdata` input 32: instruction word for the response.
- `redirect_valid` input 1: flush and restart at `redirect_pc`.
- `redirect_pc` input 32: new fetch PC; bits [1:0] are ignored and treated as 0.
- `fetch_valid` output 1: head entry is valid for decode.
- `fetch_pc` output 32: PC of the head entry.
- `fetch_instr` output 32: instruction of the head entry.
- `fetch_ready` input 1: decode consumes the head when `fetch_valid & fetch_ready`.

## Operation
- **State:**
  - `fetch_addr`: next request address.
  - `resp_pc`: PC of the next kept response.
  - `inflight`: granted but not yet answered, 0..DEPTH.
  - `drop_cnt`: in-flight responses to discard, ≤ `inflight`.
  - FIFO of {pc, instr} with `count`.
- **Request:** `imem_req = !reset & !redirect_valid & (count + inflight < DEPTH)`, and `imem_addr = fetch_addr`.
  - This credit rule guarantees every response has a free FIFO slot; no response is ever back-pressured.
  - On grant, `fetch_addr += 4`, wrapping mod 2^32.
- **Response:**
  - If `drop_cnt > 0`: discard the response and decrement `drop_cnt`.
  - Otherwise: push {`resp_pc`, `imem_rdata`} and set `resp_pc += 4`.
  - Either way, `inflight` decrements.
- **Output:** `fetch_valid = (count != 0) & !redirect_valid`, and `fetch_pc`/`fetch_instr` come from the FIFO head. A pop occurs on `fetch_valid & fetch_ready`.
- **Redirect cycle:**
  - FIFO is cleared.
  - `fetch_addr` and `resp_pc` are set to `{redirect_pc[31:2], 2'b00}`.
  - `drop_cnt` is set to the next value of `inflight`, which is `inflight - imem_rvalid`; no grant is possible that cycle.
  - Any pop or push that cycle is ignored.
- **Simultaneous events outside redirect:** push and pop in the same cycle leave `count` unchanged. Grant and response in the same cycle leave `inflight` unchanged.
- **Reset:**
  - FIFO and all counters are cleared, `fetch_addr = resp_pc = RESET_PC`.
  - The instruction memory is reset with the core, so no pre-reset response arrives afterwards.
- **Protocol violation:** `imem_rvalid` with `inflight == 0` is an error. It is flagged by an assertion, and the state is left unchanged.

## Timing
- Reset values:
  - `imem_req` = 0 while `reset` is high.
  - `fetch_valid` = 0.
  - `fetch_pc` and `fetch_instr` = 0 (empty-FIFO read value).
- The first request is offered in the first cycle after reset deasserts.
- Latency: grant at cycle t, response at t+1 at the earliest, `fetch_valid` at t+2. There is no bypass from response to output.
- Sustained throughput is 1 instruction/cycle with a zero-wait memory and decode always ready.
- After a redirect in cycle r, the new-stream request is offered at r+1, provided a credit is available.
- Counter widths are `$clog2(DEPTH+1)`.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_entry_t` = packed {pc[31:0], instr[31:0]}.
  - `XLEN = 32`.
  - `NOP_INSTR = 32'h0000_0013`, used by decode for bubbles.
- One sub-module, `fetch_fifo`:
  - Parameterized by `DEPTH` and element type.
  - Provides push, pop, flush, count and head.
  - Simultaneous push+pop is allowed when full or empty, as permitted by the credit rule.

## Test plan
- **Streaming:** reset, memory grants every cycle and responds after 1 cycle, decode always ready. Expect `fetch_pc` = 0, 4, 8, … on consecutive cycles, with the first `fetch_valid` 2 cycles after the first grant.
- **Back-pressure:** `fetch_ready = 0`. Expect exactly DEPTH grants, then `imem_req` = 0. Release ready: entries drain in order and requests resume.
- **Redirect with in-flight:** memory latency 3 cycles, redirect to 32'h100 while 3 requests are in flight. Expect those 3 responses discarded, then `fetch_pc` = 0x100, 0x104.
- **Redirect coincident with a response:** response and redirect in the same cycle. Expect `drop_cnt = inflight - 1` and no stale PC emitted. Also `redirect_pc = 32'h103` yields a fetch at 0x100.
- **Wrap:** `RESET_PC = 32'hFFFF_FFF8`. Expect the PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Reset mid-stream:** FIFO full and 2 requests in flight, then assert reset for 1 cycle. Expect `fetch_valid` = 0 and `imem_req` = 0 during reset, and the next fetch at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core types: XLEN, the decode bubble encoding,
// and the fetch->decode bundle {pc, instr}.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of T with push/pop/flush; head reads '0 when empty.
// Ports: clk, reset, push, push_data, pop, flush -> count, head.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output T                           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when a pop frees the slot.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: issues imem word requests under a credit limit,
// buffers {pc, instr} and hands them to decode; redirect flushes.
// Ports: clk, reset, imem_req/addr/gnt/rvalid/rdata,
//        redirect_valid/pc, fetch_valid/pc/instr/ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_instr,
  input  logic            fetch_ready
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_use;
  logic [XLEN-1:0] redirect_base;
  logic            grant;
  logic            rsp;
  logic            keep;
  logic            push;
  logic            pop;
  logic            unused_pc_bits;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Every granted request owns a FIFO slot, so responses never stall.
  assign credit_use = {1'b0, count} + {1'b0, inflight};
  assign imem_req   = ~reset & ~redirect_valid
                    & (credit_use < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_addr;
  assign grant      = imem_req & imem_gnt;

  // An orphan response is ignored so state stays consistent.
  assign rsp  = imem_rvalid & (inflight != '0);
  assign keep = rsp & (drop_cnt == '0);
  assign push = keep & ~redirect_valid;
  assign pop  = fetch_valid & fetch_ready;

  assign wdata.pc    = resp_pc;
  assign wdata.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wdata),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign fetch_valid = ~reset & ~redirect_valid & (count != '0);
  assign fetch_pc    = head.pc;
  assign fetch_instr = head.instr;

  always_comb begin
    inflight_next = inflight;
    unique case (1'b1)
      grant & ~rsp: inflight_next = inflight + CW'(1);
      rsp & ~grant: inflight_next = inflight - CW'(1);
      default:      inflight_next = inflight;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr <= RESET_PC;
      resp_pc    <= RESET_PC;
      inflight   <= '0;
      drop_cnt   <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        fetch_addr <= redirect_base;
        resp_pc    <= redirect_base;
        // No grant this cycle, so this is inflight minus any response.
        drop_cnt   <= inflight_next;
      end else begin
        if (grant) begin
          fetch_addr <= fetch_addr + 32'd4;
        end
        if (rsp) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            resp_pc <= resp_pc + 32'd4;
          end
        end
      end
    end
  end

  a_no_orphan_rsp: assert property (
    @(posedge clk) disable iff (reset)
    imem_rvalid |-> (inflight != '0)
  );

endmodule
